// File: rtl/sd_ctrl_pkg.sv
// Shared types and constants for the SD single-block read path.
// Optional data/command CRC is enabled by SD_DATA_CRC_CHECK_EN.
package sd_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_CMD,
        S_R1,
        S_TOKEN,
        S_DATA,
        S_CRC,
        S_REL,
        S_ERR
    } state_t;

    localparam logic [2:0] ERR_OK            = 3'd0;
    localparam logic [2:0] ERR_R1_TIMEOUT    = 3'd1;
    localparam logic [2:0] ERR_R1            = 3'd2;
    localparam logic [2:0] ERR_DATA_TOKEN    = 3'd3;
    localparam logic [2:0] ERR_TOKEN_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_ADDR          = 3'd5;
    localparam logic [2:0] ERR_CRC           = 3'd6;

    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] FILLER      = 8'hFF;

    localparam int BLOCK_BYTES = 512;

    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    function automatic logic [7:0] cmd_byte(
        input logic [2:0]  idx,
        input logic [31:0] arg,
        input logic [7:0]  crc
    );
        logic [7:0] b;
        unique case (idx)
            3'd0:    b = CMD17;
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            default: b = crc;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_read_arbiter_if.sv
// Requester and SPI-engine bundle for the SD read arbiter.
// slave = arbiter side, master = requesters plus byte engine.
interface sd_read_arbiter_if;

    logic [1:0]       req_valid;
    logic [1:0][31:0] req_sector;
    logic [1:0]       req_ready;
    logic [7:0]       rd_data;
    logic             rd_valid;
    logic             rd_last;
    logic             rd_owner;
    logic [1:0]       done;
    logic [1:0]       err;
    logic [2:0]       err_code;
    logic             spi_cs;
    logic             spi_start;
    logic [7:0]       spi_tx;
    logic             spi_done;
    logic [7:0]       spi_rx;

    modport slave (
        input  req_valid, req_sector, spi_done, spi_rx,
        output req_ready, rd_data, rd_valid, rd_last, rd_owner,
        output done, err, err_code, spi_cs, spi_start, spi_tx
    );

    modport master (
        output req_valid, req_sector, spi_done, spi_rx,
        input  req_ready, rd_data, rd_valid, rd_last, rd_owner,
        input  done, err, err_code, spi_cs, spi_start, spi_tx
    );

endinterface

// File: rtl/sd_crc_unit.sv
// Byte-wide CRC7 (command) and CRC16-CCITT (data) update, MSB first.
// Used only when SD_DATA_CRC_CHECK_EN is defined.
module sd_crc_unit
    import sd_ctrl_pkg::*;
(
    input  logic [6:0]  crc7,
    input  logic [7:0]  crc7_byte,
    output logic [6:0]  crc7_next,
    input  logic [15:0] crc16,
    input  logic [7:0]  crc16_byte,
    output logic [15:0] crc16_next
);

    logic [6:0]  c7;
    logic [15:0] c16;
    logic        fb7;
    logic        fb16;

    always_comb begin
        c7   = crc7;
        c16  = crc16;
        fb7  = 1'b0;
        fb16 = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            fb7  = c7[6] ^ crc7_byte[i];
            c7   = {c7[5:0], 1'b0};
            if (fb7) c7 = c7 ^ CRC7_POLY;
            fb16 = c16[15] ^ crc16_byte[i];
            c16  = {c16[14:0], 1'b0};
            if (fb16) c16 = c16 ^ CRC16_POLY;
        end
        crc7_next  = c7;
        crc16_next = c16;
    end

endmodule

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter running one CMD17 block read per grant over SPI.
// Define SD_DATA_CRC_CHECK_EN to generate CMD CRC7 and verify data CRC16.
module sd_read_arbiter
    import sd_ctrl_pkg::*;
#(
    parameter int R1_POLL_MAX    = 8,
    parameter int TOKEN_POLL_MAX = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic init_ok,
    input  logic card_sdhc,
    sd_read_arbiter_if.slave bus
);

    state_t      state;
    logic        busy;
    logic        fail;
    logic        owner;
    logic        rr;
    logic        pick;
    logic [31:0] sector;
    logic [31:0] arg;
    logic [2:0]  idx;
    logic [2:0]  ecode;
    logic [12:0] poll;
    logic [9:0]  bcnt;
    logic [7:0]  crc_byte;
    logic [7:0]  cmd_tx;
    logic [1:0]  owner_hot;

`ifdef SD_DATA_CRC_CHECK_EN
    logic [6:0]  crc7;
    logic [6:0]  crc7_nxt;
    logic [15:0] crc16;
    logic [15:0] crc16_nxt;
    logic [7:0]  crc_hi;

    sd_crc_unit u_crc (
        .crc7       (crc7),
        .crc7_byte  (cmd_tx),
        .crc7_next  (crc7_nxt),
        .crc16      (crc16),
        .crc16_byte (bus.spi_rx),
        .crc16_next (crc16_nxt)
    );

    assign crc_byte = {crc7, 1'b1};
`else
    assign crc_byte = FILLER;
`endif

    // Tie: the requester not granted last wins.
    assign pick      = (&bus.req_valid) ? ~rr : bus.req_valid[1];
    assign owner_hot = owner ? 2'b10 : 2'b01;
    assign cmd_tx    = cmd_byte(idx, arg, crc_byte);

    assign bus.rd_valid = (state == S_DATA) && busy && bus.spi_done;
    assign bus.rd_data  = bus.rd_valid ? bus.spi_rx : 8'h00;
    assign bus.rd_last  = bus.rd_valid
                       && (bcnt == 10'(BLOCK_BYTES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            fail          <= 1'b0;
            owner         <= 1'b0;
            rr            <= 1'b1;
            sector        <= '0;
            arg           <= '0;
            idx           <= '0;
            ecode         <= ERR_OK;
            poll          <= '0;
            bcnt          <= '0;
            bus.spi_cs    <= 1'b1;
            bus.spi_start <= 1'b0;
            bus.spi_tx    <= FILLER;
            bus.req_ready <= '0;
            bus.rd_owner  <= 1'b0;
            bus.done      <= '0;
            bus.err       <= '0;
            bus.err_code  <= ERR_OK;
`ifdef SD_DATA_CRC_CHECK_EN
            crc7          <= '0;
            crc16         <= '0;
            crc_hi        <= '0;
`endif
        end else begin
            bus.spi_start <= 1'b0;
            bus.req_ready <= '0;
            bus.done      <= '0;
            bus.err       <= '0;
            unique case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (init_ok && |bus.req_valid) begin
                        owner         <= pick;
                        rr            <= pick;
                        bus.rd_owner  <= pick;
                        bus.req_ready <= pick ? 2'b10 : 2'b01;
                        sector        <= bus.req_sector[pick];
                        fail          <= 1'b0;
                        state         <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    idx <= '0;
`ifdef SD_DATA_CRC_CHECK_EN
                    crc7 <= '0;
`endif
                    if (card_sdhc) begin
                        arg        <= sector;
                        bus.spi_cs <= 1'b0;
                        state      <= S_CMD;
                    end else if (|sector[31:23]) begin
                        ecode <= ERR_ADDR;
                        state <= S_ERR;
                    end else begin
                        arg        <= {sector[22:0], 9'd0};
                        bus.spi_cs <= 1'b0;
                        state      <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (!busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_tx    <= cmd_tx;
                        busy          <= 1'b1;
`ifdef SD_DATA_CRC_CHECK_EN
                        crc7 <= crc7_nxt;
`endif
                    end else if (bus.spi_done) begin
                        busy <= 1'b0;
                        if (idx == 3'd5) begin
                            poll  <= '0;
                            state <= S_R1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_R1: begin
                    if (!busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_tx    <= FILLER;
                        busy          <= 1'b1;
                    end else if (bus.spi_done) begin
                        busy <= 1'b0;
                        if (!bus.spi_rx[7]) begin
                            if (bus.spi_rx == 8'h00) begin
                                poll  <= '0;
                                state <= S_TOKEN;
                            end else begin
                                ecode <= ERR_R1;
                                state <= S_ERR;
                            end
                        end else if (poll == 13'(R1_POLL_MAX - 1)) begin
                            ecode <= ERR_R1_TIMEOUT;
                            state <= S_ERR;
                        end else begin
                            poll <= poll + 13'd1;
                        end
                    end
                end
                S_TOKEN: begin
                    if (!busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_tx    <= FILLER;
                        busy          <= 1'b1;
                    end else if (bus.spi_done) begin
                        busy <= 1'b0;
                        if (bus.spi_rx == START_TOKEN) begin
                            bcnt  <= '0;
                            state <= S_DATA;
`ifdef SD_DATA_CRC_CHECK_EN
                            crc16 <= '0;
`endif
                        end else if (bus.spi_rx[7:4] == 4'h0) begin
                            ecode <= ERR_DATA_TOKEN;
                            state <= S_ERR;
                        end else if (poll == 13'(TOKEN_POLL_MAX - 1)) begin
                            ecode <= ERR_TOKEN_TIMEOUT;
                            state <= S_ERR;
                        end else begin
                            poll <= poll + 13'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (!busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_tx    <= FILLER;
                        busy          <= 1'b1;
                    end else if (bus.spi_done) begin
                        busy <= 1'b0;
`ifdef SD_DATA_CRC_CHECK_EN
                        crc16 <= crc16_nxt;
`endif
                        if (bcnt == 10'(BLOCK_BYTES - 1)) begin
                            idx   <= '0;
                            state <= S_CRC;
                        end else begin
                            bcnt <= bcnt + 10'd1;
                        end
                    end
                end
                S_CRC: begin
                    if (!busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_tx    <= FILLER;
                        busy          <= 1'b1;
                    end else if (bus.spi_done) begin
                        busy <= 1'b0;
                        if (idx == 3'd0) begin
                            idx <= 3'd1;
`ifdef SD_DATA_CRC_CHECK_EN
                            crc_hi <= bus.spi_rx;
`endif
                        end else begin
`ifdef SD_DATA_CRC_CHECK_EN
                            if ({crc_hi, bus.spi_rx} != crc16) begin
                                ecode <= ERR_CRC;
                                state <= S_ERR;
                            end else begin
                                bus.spi_cs <= 1'b1;
                                state      <= S_REL;
                            end
`else
                            bus.spi_cs <= 1'b1;
                            state      <= S_REL;
`endif
                        end
                    end
                end
                // Card is deselected before the trailing filler byte.
                S_REL: begin
                    if (!busy) begin
                        bus.spi_start <= 1'b1;
                        bus.spi_tx    <= FILLER;
                        busy          <= 1'b1;
                    end else if (bus.spi_done) begin
                        busy <= 1'b0;
                        if (!fail) bus.done <= owner_hot;
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    bus.err      <= owner_hot;
                    bus.err_code <= ecode;
                    bus.spi_cs   <= 1'b1;
                    fail         <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_REL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Scoreboard bench for sd_read_arbiter with a scripted SPI card model.
// Honours SD_DATA_CRC_CHECK_EN for the CRC-dependent expectations.
module tb_sd_read_arbiter;

    logic clk;
    logic reset;
    logic init_ok;
    logic card_sdhc;

    sd_read_arbiter_if bus ();

    sd_read_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .init_ok   (init_ok),
        .card_sdhc (card_sdhc),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       is_err;
        bit       owner;
        bit [2:0] code;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         last;
        bit         owner;
    } by_t;

    ev_t ev_q[$];
    by_t by_q[$];

    int tests = 0;
    int fails = 0;
    bit cs_low_seen = 0;

    // card model configuration
    logic [7:0] r1_val = 8'h00;
    bit         r1_never = 0;
    logic [7:0] tok_val = 8'hFE;
    bit         tok_never = 0;
    int         corrupt_idx = -1;
    logic [15:0] crc_ref;

    int phase = 0;
    int n = 0;
    int p = 0;
    int t = 0;
    int d = 0;
    int c = 0;
    int r1_polls = 0;
    int tok_polls = 0;
    logic [7:0] cmd [6];
    bit         pending = 0;
    logic [7:0] resp = 8'hFF;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16_of_block();
        logic [15:0] r = 16'h0;
        logic [7:0]  b;
        for (int i = 0; i < 512; i++) begin
            b = 8'(i);
            for (int k = 7; k >= 0; k--) begin
                if (r[15] ^ b[k]) r = {r[14:0], 1'b0} ^ 16'h1021;
                else r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction

    // SPI byte engine + card: answer one cycle after spi_start
    initial begin
        bus.spi_done = 1'b0;
        bus.spi_rx   = 8'hFF;
        forever begin
            @(posedge clk);
            #1;
            bus.spi_done = 1'b0;
            if (reset) begin
                pending = 0;
                phase   = 0;
                n       = 0;
                continue;
            end
            if (pending) begin
                bus.spi_done = 1'b1;
                bus.spi_rx   = resp;
                pending      = 0;
            end
            if (bus.spi_start) begin
                pending = 1;
                resp    = 8'hFF;
                if (bus.spi_cs) begin
                    phase = 0;
                    n     = 0;
                end else begin
                    case (phase)
                        0: begin
                            cmd[n] = bus.spi_tx;
                            n++;
                            if (n == 6) begin phase = 1; p = 0; end
                        end
                        1: begin
                            p++;
                            r1_polls = p;
                            if (!r1_never && p == 2) begin
                                resp  = r1_val;
                                phase = (r1_val == 8'h00) ? 2 : 5;
                                t     = 0;
                            end
                        end
                        2: begin
                            t++;
                            tok_polls = t;
                            if (!tok_never && t == 3) begin
                                resp  = tok_val;
                                phase = (tok_val == 8'hFE) ? 3 : 5;
                                d     = 0;
                            end
                        end
                        3: begin
                            resp = 8'(d);
                            if (d == corrupt_idx) resp = resp ^ 8'h01;
                            d++;
                            if (d == 512) begin phase = 4; c = 0; end
                        end
                        4: begin
                            resp = (c == 0) ? crc_ref[15:8] : crc_ref[7:0];
                            c++;
                            if (c == 2) phase = 5;
                        end
                        default: resp = 8'hFF;
                    endcase
                end
            end
        end
    end

    // monitor: compare every data byte and completion against the queues
    initial begin
        by_t b;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!bus.spi_cs) cs_low_seen = 1;
            if (bus.rd_valid) begin
                if (by_q.size() == 0) begin
                    chk("rd_unexpected", {23'd0, bus.rd_last, bus.rd_data},
                        32'hFFFF_FFFF);
                end else begin
                    b = by_q.pop_front();
                    chk("rd_byte",
                        {22'd0, bus.rd_last, bus.rd_owner, bus.rd_data},
                        {22'd0, b.last, b.owner, b.data});
                end
            end
            if (bus.done != 2'b00 || bus.err != 2'b00) begin
                if (ev_q.size() == 0) begin
                    chk("event_unexpected", {28'd0, bus.err, bus.done}, 32'd0);
                end else begin
                    e = ev_q.pop_front();
                    chk("event",
                        {25'd0, bus.err, bus.done,
                         (bus.err != 2'b00) ? bus.err_code : 3'd0},
                        {25'd0,
                         e.is_err ? (e.owner ? 2'b10 : 2'b01) : 2'b00,
                         e.is_err ? 2'b00 : (e.owner ? 2'b10 : 2'b01),
                         e.is_err ? e.code : 3'd0});
                end
            end
        end
    end

    task automatic push_block(input bit o, input int corrupt);
        by_t b;
        for (int i = 0; i < 512; i++) begin
            b.data  = 8'(i);
            if (i == corrupt) b.data = b.data ^ 8'h01;
            b.last  = (i == 511);
            b.owner = o;
            by_q.push_back(b);
        end
    endtask

    task automatic push_ev(input bit is_err, input bit o, input bit [2:0] code);
        ev_t e;
        e.is_err = is_err;
        e.owner  = o;
        e.code   = code;
        ev_q.push_back(e);
    endtask

    task automatic request(input int o, input logic [31:0] s);
        int k = 0;
        bus.req_sector[o] = s;
        bus.req_valid[o]  = 1'b1;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.req_ready[o] && k < 30000);
        if (!bus.req_ready[o]) chk("grant_timeout", 32'(o), 32'hFF);
        bus.req_valid[o] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (ev_q.size() != 0 && k < 30000) begin
            @(negedge clk);
            k++;
        end
        if (ev_q.size() != 0) begin
            chk({name, "_timeout"}, 32'(ev_q.size()), 32'd0);
            ev_q.delete();
        end
        repeat (4) @(negedge clk);
        chk({name, "_bytes_left"}, 32'(by_q.size()), 32'd0);
        by_q.delete();
        chk({name, "_cs_idle"}, 32'(bus.spi_cs), 32'd1);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_cs"}, 32'(bus.spi_cs), 32'd1);
        chk({name, "_start"}, 32'(bus.spi_start), 32'd0);
        chk({name, "_tx"}, 32'(bus.spi_tx), 32'hFF);
        chk({name, "_misc"},
            {20'd0, bus.req_ready, bus.rd_valid, bus.rd_last,
             bus.done, bus.err, bus.err_code, bus.rd_owner},
            32'd0);
    endtask

    initial begin
        bit seen;
        reset          = 1'b1;
        init_ok        = 1'b1;
        card_sdhc      = 1'b1;
        bus.req_valid  = 2'b00;
        bus.req_sector = '0;
        crc_ref        = crc16_of_block();
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        reset = 1'b0;

        // request without init_ok, dropped before any grant
        init_ok = 1'b0;
        seen    = 0;
        bus.req_sector[0] = 32'd1;
        bus.req_valid[0]  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) seen = 1;
        end
        bus.req_valid[0] = 1'b0;
        init_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00 || !bus.spi_cs) seen = 1;
        end
        chk("drop_no_grant", 32'(seen), 32'd0);

        // both requesters, three back-to-back requests each
        for (int i = 0; i < 6; i++) begin
            push_block(i[0], -1);
            push_ev(0, i[0], 3'd0);
        end
        fork
            begin
                for (int i = 0; i < 3; i++) request(0, 32'(10 + i));
            end
            begin
                for (int i = 0; i < 3; i++) request(1, 32'(20 + i));
            end
        join
        wait_idle("rr");

        // SDHC, sector 5
        push_block(0, -1);
        push_ev(0, 0, 3'd0);
        request(0, 32'd5);
        wait_idle("sdhc5");
        chk("sdhc5_cmd",
            {cmd[0], cmd[1], cmd[2], cmd[3]}, 32'h5100_0000);
        chk("sdhc5_arg0", 32'(cmd[4]), 32'h05);

        // byte addressing, sector 3 -> 0x600
        card_sdhc = 1'b0;
        push_block(1, -1);
        push_ev(0, 1, 3'd0);
        request(1, 32'd3);
        wait_idle("sdsc3");
        chk("sdsc3_arg",
            {cmd[1], cmd[2], cmd[3], cmd[4]}, 32'h0000_0600);

        // byte addressing out of range
        cs_low_seen = 0;
        push_ev(1, 0, 3'd5);
        request(0, 32'h0080_0000);
        wait_idle("range");
        chk("range_cs_never_low", 32'(cs_low_seen), 32'd0);
        card_sdhc = 1'b1;

        // command CRC byte for CMD17 arg 0
        push_block(0, -1);
        push_ev(0, 0, 3'd0);
        request(0, 32'd0);
        wait_idle("arg0");
`ifdef SD_DATA_CRC_CHECK_EN
        chk("arg0_crc7", 32'(cmd[5]), 32'h55);
`else
        chk("arg0_crc7", 32'(cmd[5]), 32'hFF);
`endif

        // R1 error response
        r1_val = 8'h04;
        push_ev(1, 1, 3'd2);
        request(1, 32'd7);
        wait_idle("r1_err");
        r1_val = 8'h00;

        // R1 never arrives
        r1_never = 1;
        push_ev(1, 0, 3'd1);
        request(0, 32'd7);
        wait_idle("r1_tmo");
        chk("r1_tmo_polls", 32'(r1_polls), 32'd8);
        r1_never = 0;

        // data error token
        tok_val = 8'h09;
        push_ev(1, 0, 3'd3);
        request(0, 32'd7);
        wait_idle("tok_err");
        tok_val = 8'hFE;

        // start token never arrives
        tok_never = 1;
        push_ev(1, 1, 3'd4);
        request(1, 32'd7);
        wait_idle("tok_tmo");
        chk("tok_tmo_polls", 32'(tok_polls), 32'd4096);
        tok_never = 0;

        // reset at data byte 100
        push_block(1, -1);
        push_ev(0, 1, 3'd0);
        request(1, 32'd8);
        begin
            int k = 0;
            while (!(phase == 3 && d >= 100) && k < 5000) begin
                @(negedge clk);
                k++;
            end
            chk("reset_reach_byte100", 32'(d >= 100), 32'd1);
        end
        #2;
        reset = 1'b1;
        ev_q.delete();
        by_q.delete();
        @(posedge clk);
        #1;
        chk_reset("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        push_block(0, -1);
        push_ev(0, 0, 3'd0);
        request(0, 32'd9);
        wait_idle("after_reset");

        // one corrupted data byte
        corrupt_idx = 7;
        push_block(1, 7);
`ifdef SD_DATA_CRC_CHECK_EN
        push_ev(1, 1, 3'd6);
`else
        push_ev(0, 1, 3'd0);
`endif
        request(1, 32'd11);
        wait_idle("corrupt");
        corrupt_idx = -1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
